// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation
// encodings, control-state enum and the default datapath width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101,
    MDU_NOP0  = 3'b110,
    MDU_NOP1  = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate, used both to take operand
// magnitudes and to restore the sign of multiply/divide results.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int W = MDU_WIDTH
) (
  input  logic         neg_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Define MDU_DIV_EN to build the restoring divider; otherwise DIV/DIVU are no-ops.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_res_q, neg_res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               is_signed_s, is_mul_s, is_div_s, op_div_s;
  logic [WIDTH-1:0]   rs_abs_s, rt_abs_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s, prod_fix_s;

  assign is_signed_s = (op == MDU_MULT) || (op == MDU_DIV);
  assign is_mul_s    = (op == MDU_MULT) || (op == MDU_MULTU);

  mdu_sign_fix #(.W(WIDTH)) u_abs_rs (
    .neg_i(is_signed_s & rs_data[WIDTH-1]), .val_i(rs_data), .val_o(rs_abs_s)
  );
  mdu_sign_fix #(.W(WIDTH)) u_abs_rt (
    .neg_i(is_signed_s & rt_data[WIDTH-1]), .val_i(rt_data), .val_o(rt_abs_s)
  );
  mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .neg_i(neg_res_q), .val_i(acc_q), .val_o(prod_fix_s)
  );

  // Shift-add: acc = {partial product, remaining multiplier bits}.
  assign mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};

`ifdef MDU_DIV_EN
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH:0]     div_trial_s, div_diff_s;
  logic               div_qbit_s;
  logic [2*WIDTH-1:0] div_next_s;
  logic [WIDTH-1:0]   quot_fix_s, rem_fix_s;

  assign is_div_s = (op == MDU_DIV) || (op == MDU_DIVU);
  assign op_div_s = (op_q == MDU_DIV) || (op_q == MDU_DIVU);

  // Restoring step: acc = {partial remainder, dividend bits / quotient bits}.
  assign div_trial_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff_s  = div_trial_s - {1'b0, opnd_q};
  assign div_qbit_s  = ~div_diff_s[WIDTH];
  assign div_next_s  = {(div_qbit_s ? div_diff_s[WIDTH-1:0] : div_trial_s[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_qbit_s};

  mdu_sign_fix #(.W(WIDTH)) u_fix_quot (
    .neg_i(neg_res_q), .val_i(acc_q[WIDTH-1:0]), .val_o(quot_fix_s)
  );
  mdu_sign_fix #(.W(WIDTH)) u_fix_rem (
    .neg_i(neg_rem_q), .val_i(acc_q[2*WIDTH-1:WIDTH]), .val_o(rem_fix_s)
  );
`else
  assign is_div_s = 1'b0;
  assign op_div_s = 1'b0;
`endif

  // Control FSM and datapath next-state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
`ifdef MDU_DIV_EN
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_mul_s || is_div_s) begin
            state_d   = CALC;
            cnt_d     = {CW{1'b0}};
            op_d      = op;
            neg_res_d = is_signed_s & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
`ifdef MDU_DIV_EN
            neg_rem_d = is_signed_s & rs_data[WIDTH-1];
`endif
            if (is_mul_s) begin
              opnd_d = rs_abs_s;
              acc_d  = {{WIDTH{1'b0}}, rt_abs_s};
            end else begin
              opnd_d = rt_abs_s;
              acc_d  = {{WIDTH{1'b0}}, rs_abs_s};
            end
          end else if (op == MDU_MTHI) begin
            hi_d = rs_data;
          end else if (op == MDU_MTLO) begin
            lo_d = rs_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
`ifdef MDU_DIV_EN
        acc_d = op_div_s ? div_next_s : mul_next_s;
`else
        acc_d = op_div_s ? acc_q : mul_next_s;
`endif
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FIX;
        end else begin
          state_d = CALC;
        end
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        case (op_q)
`ifdef MDU_DIV_EN
          MDU_DIV, MDU_DIVU: begin
            // Divide by zero leaves quotient all-ones; remainder path returns rs.
            lo_d = (opnd_q == {WIDTH{1'b0}}) ? {WIDTH{1'b1}} : quot_fix_s;
            hi_d = rem_fix_s;
          end
`endif
          default: begin
            {hi_d, lo_d} = prod_fix_s;
          end
        endcase
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and architectural register update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      op_q      <= 3'b000;
      opnd_q    <= {WIDTH{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      neg_res_q <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      done_q    <= 1'b0;
`ifdef MDU_DIV_EN
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
`ifdef MDU_DIV_EN
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Randomized self-checking bench for mdu_hilo against an arithmetic
// reference model of the HI/LO architectural state.
module tb_mdu_hilo;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] hi_m, lo_m;

  mdu_hilo #(.WIDTH(32)) dut (
    .clk(clk), .reset(rst_n), .start(start), .op(op),
    .rs_data(rs), .rt_data(rt), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_calc(input logic [2:0] o);
    return (o == 3'd0) || (o == 3'd1) || (DIV_EN && ((o == 3'd2) || (o == 3'd3)));
  endfunction

  // Reference model: architectural effect of one accepted operation.
  task automatic model_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    case (o)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {hi_m, lo_m} = sp;
      end
      3'd1: begin
        up = {32'd0, a} * {32'd0, b};
        {hi_m, lo_m} = up;
      end
      3'd2, 3'd3: begin
        if (DIV_EN) begin
          if (b == 32'd0) begin
            lo_m = 32'hFFFF_FFFF;
            hi_m = a;
          end else if (o == 3'd2) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
              lo_m = 32'h8000_0000;
              hi_m = 32'd0;
            end else begin
              sa = a;
              sb = b;
              lo_m = sa / sb;
              hi_m = sa % sb;
            end
          end else begin
            lo_m = a / b;
            hi_m = a % b;
          end
        end
      end
      3'd4: hi_m = a;
      3'd5: lo_m = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit inj);
    logic [31:0] hi_old, lo_old;
    int cyc;
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk); #1;
    start = 1'b0;
    hi_old = hi_m;
    lo_old = lo_m;
    model_apply(o, a, b);
    if (!is_calc(o)) begin
      check("imm_busy", busy, 1'b0);
      check("imm_done", done, 1'b0);
      check("imm_hi", hi, hi_m);
      check("imm_lo", lo, lo_m);
    end else begin
      check("start_busy", busy, 1'b1);
      check("start_done", done, 1'b0);
      cyc = 0;
      while (!done && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
        if (inj && cyc == 5) begin
          start = 1'b1; op = 3'd5; rs = 32'h55;
        end
        if (inj && cyc == 6) start = 1'b0;
        if (cyc == 17) begin
          check("hold_busy", busy, 1'b1);
          check("hold_hi", hi, hi_old);
          check("hold_lo", lo, lo_old);
        end
      end
      check("latency", 64'(cyc), 64'd33);
      check("end_busy", busy, 1'b0);
      check("res_hi", hi, hi_m);
      check("res_lo", lo, lo_m);
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'hFFFF_FFFF - 32'($urandom_range(0, 8));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    rst_n = 1'b0; start = 1'b0; op = 3'd0; rs = 32'd0; rt = 32'd0;
    hi_m = 32'd0; lo_m = 32'd0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'd3, 32'd100, 32'd0, 1'b0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd4, 32'h0000_1234, 32'd0, 1'b0);
    run_op(3'd0, 32'h1234_5678, 32'hFFFF_FF00, 1'b1);
    run_op(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs = 32'd9; rt = 32'd11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    hi_m = 32'd0; lo_m = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("midrst_no_done", 64'(seen), 64'd0);
    run_op(3'd0, 32'd6, 32'd7, 1'b0);
    check("six_by_seven", lo, 32'd42);

    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), rnd_val(), rnd_val(), 1'b0);
    end

    @(posedge clk); #1;
    check("final_done_low", done, 1'b0);
    check("final_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Iterative multiply/divide unit with HI/LO registers for the single-cycle MIPS core. It consumes the two register-file read ports (rs, rt) and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Results are held in architectural HI/LO registers for MFHI/MFLO. While a multi-cycle operation runs, the unit asserts `busy`, and the core stalls any HI/LO access until it clears.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width; iteration count equals `WIDTH`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low; clears all state.
- `start`, input, 1: request strobe; sampled only when `busy`=0.
- `op`, input, 3: operation select:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are no-ops.
- `rs_data`, input, WIDTH: register-file read data 1 (multiplicand, dividend, or MTHI/MTLO source).
- `rt_data`, input, WIDTH: register-file read data 2 (multiplier or divisor).
- `busy`, output, 1: a multi-cycle operation is in flight.
- `done`, output, 1: one-cycle pulse when HI/LO receive a MULT/DIV result.
- `hi`, output, WIDTH: HI register.
- `lo`, output, WIDTH: LO register.

## Operation
- **States:**
  - IDLE: on `start` with a MULT/DIV op, go to CALC; otherwise stay.
  - CALC: iteration counter runs 0..WIDTH-1; at count WIDTH-1, go to FIX.
  - FIX: write HI/LO, pulse `done`, return to IDLE.
- **Capture at start:**
  - Latch the op.
  - Latch operand magnitudes: absolute values for signed ops, raw values for unsigned.
  - Latch the result-sign flags.
- **Multiply:** shift-add, one bit per cycle, into a 2·WIDTH accumulator. In FIX:
  - Negate the product if the signs of `rs` and `rt` differ (signed op only).
  - HI takes the upper WIDTH bits; LO takes the lower WIDTH bits.
- **Divide:** restoring, one quotient bit per cycle. In FIX:
  - Negate the quotient if the operand signs differ.
  - The remainder takes the dividend's sign.
  - LO = quotient, HI = remainder.
- **Divide by zero** (`rt`=0), DIV and DIVU: full latency, then LO=all-ones, HI=`rs_data` unchanged.
- **Signed overflow** (0x80000000 / -1): LO=0x80000000, HI=0.
- **MTHI/MTLO:**
  - Written at the edge where `start` is sampled.
  - `busy` stays 0; no `done` pulse.
- **No-op encodings:** ignored.
- **`start` while `busy`=1:** ignored; operands are not re-captured.
- **Reset (asserted at any time, including mid-operation):**
  - State returns to IDLE.
  - `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - The in-flight operation is discarded.

## Timing
- Edge E0 samples `start` (MULT/DIV). `busy` is 1 from after E0 until E33, i.e. 33 cycles.
- E1..E32 perform the WIDTH iterations; FIX is occupied after E32.
- E33 writes HI/LO, drops `busy`, and raises `done` for exactly one cycle.
- Results are visible on `hi`/`lo` after E33: latency WIDTH+1 edges.
- A new `start` is accepted in the cycle where `done`=1, i.e. back-to-back issue.
- `hi`/`lo` hold their previous values throughout CALC and FIX.
- MTHI/MTLO have single-edge latency.

## Configuration
- `MDU_DIV_EN` defined:
  - Divider datapath compiled in.
  - DIV and DIVU behave as specified above.
- `MDU_DIV_EN` undefined:
  - No divider logic is present.
  - DIV and DIVU are treated as no-ops: HI/LO unchanged, `busy` stays 0, no `done` pulse.
  - Multiply, MTHI and MTLO are unaffected.

## Structure
- Shared package `mdu_pkg` holds:
  - op encodings (`MDU_MULT` … `MDU_MTLO`);
  - the state enum (IDLE, CALC, FIX);
  - default `WIDTH`.
- One sub-module, `mdu_sign_fix`: combinational conditional two's-complement negate.
  - Used for operand absolute value.
  - Used for result sign correction.
- The iteration datapath stays in the top level.

## Test plan
- MULT with `rs`=-3, `rt`=5 → after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1; `done` high for one cycle.
- MULTU with 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV with -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU with 100/0 → LO=0xFFFFFFFF, HI=0x00000064.
- MTHI 0x1234, then `start` asserted again mid-MULT (`busy`=1) with MTLO 0x55 → HI=0x1234 after one edge; MTLO is ignored; MULT result still lands at E33.
- MULT started, then `reset` pulled low at cycle 10 → `busy`=0, `hi`=`lo`=0 immediately; no `done` pulse; a fresh MULT 6×7 afterwards gives LO=42.
